keypad_safe_ctrl: RTL and testbench

KEYPAD_SAFE_CTRL -- requirements
Module: keypad_safe_ctrl

---
 rtl/keypad_safe_ctrl.sv | 177 +++++++++++++++++
 tb/tb_keypad_safe_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_safe_ctrl.sv
// Keypad safe controller: digit entry, password compare, password change,
// and timed lockout after repeated wrong attempts. All outputs are registered.
module keypad_safe_ctrl #(
    parameter int PW_LEN         = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              initialize_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              reset_password,
    output logic [PW_LEN-1:0] password_led,
    output logic [2:0]        state,
    output logic              unlocked,
    output logic              alarm,
    output logic [3:0]        fail_cnt
);

    localparam int CW = $clog2(PW_LEN + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] PW_LEN_C    = CW'(PW_LEN);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    MAX_FAIL_C  = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SET_PW  = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t                  state_q, state_n;
    logic [PW_LEN-1:0][3:0]  pw_q, pw_n;
    logic [PW_LEN-1:0][3:0]  buf_q, buf_n;
    logic [CW-1:0]           count_q, count_n;
    logic [3:0]              fail_q, fail_n;
    logic [TW-1:0]           timer_q, timer_n;
    logic [PW_LEN-1:0]       led_q, led_n;
    logic                    unlocked_q, alarm_q;

    logic is_digit, is_star, is_sharp;
    logic full, match;
    logic [3:0] fail_inc;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_star  = key_valid && (key_code == 4'd10);
    assign is_sharp = key_valid && (key_code == 4'd11);
    assign full     = (count_q == PW_LEN_C);
    assign match    = full && (buf_q == pw_q);
    assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n = state_q;
        pw_n    = pw_q;
        buf_n   = buf_q;
        count_n = count_q;
        fail_n  = fail_q;
        timer_n = timer_q;

        unique case (state_q)
            ST_LOCKED: begin
                if (is_digit) begin
                    buf_n    = '0;
                    buf_n[0] = key_code;
                    count_n  = CW'(1);
                    state_n  = ST_ENTRY;
                end else if (is_star || is_sharp) begin
                    buf_n   = '0;
                    count_n = '0;
                end
            end
            ST_ENTRY, ST_SET_PW: begin
                if (is_digit) begin
                    // Digits beyond PW_LEN are silently dropped.
                    if (!full) begin
                        for (int i = 0; i < PW_LEN; i++)
                            if (CW'(i) == count_q) buf_n[i] = key_code;
                        count_n = count_q + CW'(1);
                    end
                end else if (is_star || is_sharp) begin
                    buf_n   = '0;
                    count_n = '0;
                    if (state_q == ST_ENTRY) begin
                        if (is_star) begin
                            state_n = ST_LOCKED;
                        end else if (match) begin
                            state_n = ST_OPEN;
                            fail_n  = '0;
                        end else begin
                            fail_n = fail_inc;
                            if (fail_inc >= MAX_FAIL_C) begin
                                state_n = ST_LOCKOUT;
                                timer_n = TIMER_LOAD;
                            end else begin
                                state_n = ST_LOCKED;
                            end
                        end
                    end else begin
                        if (is_star) begin
                            state_n = ST_OPEN;
                        end else if (full) begin
                            pw_n    = buf_q;
                            state_n = ST_OPEN;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (reset_password) begin
                    buf_n   = '0;
                    count_n = '0;
                    state_n = ST_SET_PW;
                end else if (is_sharp) begin
                    buf_n   = '0;
                    count_n = '0;
                    state_n = ST_LOCKED;
                end else if (is_star) begin
                    buf_n   = '0;
                    count_n = '0;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_n = ST_LOCKED;
                    fail_n  = '0;
                end else begin
                    timer_n = timer_q - TW'(1);
                end
            end
            default: begin
                state_n = ST_LOCKED;
                buf_n   = '0;
                count_n = '0;
                timer_n = '0;
            end
        endcase

        for (int i = 0; i < PW_LEN; i++)
            led_n[i] = (count_n > CW'(i));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (!initialize_n) begin
            state_q    <= ST_LOCKED;
            // NOTE: the password store is reset too, since a known 0000 code is part of the reset contract.
            pw_q       <= '0;
            buf_q      <= '0;
            count_q    <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            led_q      <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            pw_q       <= pw_n;
            buf_q      <= buf_n;
            count_q    <= count_n;
            fail_q     <= fail_n;
            timer_q    <= timer_n;
            led_q      <= led_n;
            unlocked_q <= (state_n == ST_OPEN) || (state_n == ST_SET_PW);
            alarm_q    <= (state_n == ST_LOCKOUT);
        end
    end

    assign state        = state_q;
    assign password_led = led_q;
    assign unlocked     = unlocked_q;
    assign alarm        = alarm_q;
    assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_keypad_safe_ctrl.sv
// Directed bench for keypad_safe_ctrl with PW_LEN=4, MAX_FAIL=3, LOCKOUT_CYCLES=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_safe_ctrl;

    logic       clk = 1'b0;
    logic       initialize_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       reset_password;
    logic [3:0] password_led;
    logic [2:0] state;
    logic       unlocked;
    logic       alarm;
    logic [3:0] fail_cnt;

    int n_checks = 0;
    int n_err    = 0;

    keypad_safe_ctrl #(
        .PW_LEN(4),
        .MAX_FAIL(3),
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .initialize_n(initialize_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .reset_password(reset_password),
        .password_led(password_led),
        .state(state),
        .unlocked(unlocked),
        .alarm(alarm),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_code(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        press(d0); press(d1); press(d2); press(d3);
    endtask

    task automatic pulse_reset_password();
        @(negedge clk);
        reset_password = 1'b1;
        @(negedge clk);
        reset_password = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        initialize_n   = 1'b0;
        key_valid      = 1'b1;
        key_code       = 4'd3;
        reset_password = 1'b0;
        repeat (2) @(negedge clk);
        initialize_n = 1'b1;
        key_valid    = 1'b0;
        @(negedge clk);
        check("rst_state",    state,        3'd0);
        check("rst_led",      password_led, 4'b0000);
        check("rst_unlocked", unlocked,     1'b0);
        check("rst_alarm",    alarm,        1'b0);
        check("rst_fail",     fail_cnt,     4'd0);

        // Default password 0000 unlocks
        press(4'd0); check("e1_led", password_led, 4'b0001); check("e1_state", state, 3'd1);
        press(4'd0); check("e2_led", password_led, 4'b0011);
        press(4'd0); check("e3_led", password_led, 4'b0111);
        press(4'd0); check("e4_led", password_led, 4'b1111);
        press(4'd11);
        check("open_state",    state,        3'd2);
        check("open_unlocked", unlocked,     1'b1);
        check("open_led",      password_led, 4'b0000);

        // Change password to 5729
        pulse_reset_password();
        check("setpw_state",    state,    3'd3);
        check("setpw_unlocked", unlocked, 1'b1);
        press_code(4'd5, 4'd7, 4'd2, 4'd9);
        check("setpw_led", password_led, 4'b1111);
        press(4'd11);
        check("setpw_commit", state, 3'd2);

        // Short sharp in SET_PW stays; star aborts to OPEN
        pulse_reset_password();
        press(4'd1); press(4'd2);
        press(4'd11);
        check("setpw_short_state", state,        3'd3);
        check("setpw_short_led",   password_led, 4'b0000);
        press(4'd1);
        press(4'd10);
        check("setpw_abort", state, 3'd2);

        // Relock, then new password opens
        press(4'd11);
        check("relock", state, 3'd0);
        press_code(4'd5, 4'd7, 4'd2, 4'd9);
        press(4'd11);
        check("new_pw_open", state, 3'd2);
        check("new_pw_fail", fail_cnt, 4'd0);
        press(4'd11);
        press_code(4'd0, 4'd0, 4'd0, 4'd0);
        press(4'd11);
        check("old_pw_state", state,    3'd0);
        check("old_pw_fail",  fail_cnt, 4'd1);

        // reset_password ignored outside OPEN; reserved keys ignored
        pulse_reset_password();
        check("rp_ignored", state, 3'd0);
        press(4'd13);
        check("reserved_locked", state, 3'd0);

        // Clear fail count with a correct entry, then three wrong entries
        press_code(4'd5, 4'd7, 4'd2, 4'd9);
        press(4'd11);
        check("clear_fail", fail_cnt, 4'd0);
        press(4'd11);
        press_code(4'd1, 4'd1, 4'd1, 4'd1); press(4'd11);
        check("wrong1_fail", fail_cnt, 4'd1); check("wrong1_state", state, 3'd0);
        press_code(4'd1, 4'd1, 4'd1, 4'd2); press(4'd11);
        check("wrong2_fail", fail_cnt, 4'd2); check("wrong2_state", state, 3'd0);
        press_code(4'd1, 4'd1, 4'd1, 4'd3);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd11;
        @(negedge clk);
        check("lockout_enter",  state,    3'd4);
        check("lockout_alarm0", alarm,    1'b1);
        check("lockout_fail",   fail_cnt, 4'd3);
        check("lockout_unl",    unlocked, 1'b0);
        for (int i = 1; i < 8; i++) begin
            key_valid = (i == 2) || (i == 3);
            key_code  = 4'd1;
            @(negedge clk);
            check($sformatf("lockout_state_%0d", i), state,        3'd4);
            check($sformatf("lockout_alarm_%0d", i), alarm,        1'b1);
            check($sformatf("lockout_led_%0d", i),   password_led, 4'b0000);
        end
        key_valid = 1'b0;
        @(negedge clk);
        check("lockout_exit",  state,    3'd0);
        check("lockout_alarm", alarm,    1'b0);
        check("lockout_clear", fail_cnt, 4'd0);

        // Star aborts entry, fail count unchanged
        press_code(4'd0, 4'd0, 4'd0, 4'd0); press(4'd11);
        check("pre_star_fail", fail_cnt, 4'd1);
        press(4'd1); press(4'd2);
        check("pre_star_led", password_led, 4'b0011);
        press(4'd10);
        check("star_state", state,        3'd0);
        check("star_led",   password_led, 4'b0000);
        check("star_fail",  fail_cnt,     4'd1);

        // Fifth digit dropped
        press_code(4'd5, 4'd7, 4'd2, 4'd9);
        press(4'd3);
        check("drop_led", password_led, 4'b1111);
        press(4'd11);
        check("drop_open", state,    3'd2);
        check("drop_fail", fail_cnt, 4'd0);
        press(4'd12);
        check("reserved_open", state, 3'd2);
        press(4'd4);
        check("digit_open_ignored", password_led, 4'b0000);

        // Reset in the middle of SET_PW
        pulse_reset_password();
        press(4'd1); press(4'd2);
        check("mid_setpw_led", password_led, 4'b0011);
        @(negedge clk);
        initialize_n = 1'b0;
        key_valid    = 1'b1;
        key_code     = 4'd3;
        @(negedge clk);
        initialize_n = 1'b1;
        key_valid    = 1'b0;
        check("mid_rst_state",    state,        3'd0);
        check("mid_rst_led",      password_led, 4'b0000);
        check("mid_rst_unlocked", unlocked,     1'b0);
        check("mid_rst_alarm",    alarm,        1'b0);
        check("mid_rst_fail",     fail_cnt,     4'd0);
        press_code(4'd0, 4'd0, 4'd0, 4'd0);
        press(4'd11);
        check("mid_rst_pw_revert", state, 3'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
